// File: rtl/pbuf2ddr.sv
// Read-back engine: streams one PE parameter buffer out to the DDR write port through a credit-checked FIFO.
// Optional feature: define PBUF2DDR_CHECKSUM_EN to add chk_sum, the XOR of all words sent since the last start.
module pbuf2ddr #(
    parameter int BUF_DEPTH  = 256,
    parameter int ADDR_W     = $clog2(BUF_DEPTH),
    parameter int PE_NUM     = 32,
    parameter int SEL_W      = $clog2(PE_NUM),
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 16,
    parameter int BATCH      = 4,
    parameter int DDR_W      = DATA_W * BATCH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    done,
    input  logic [7:0]              conf_trans_num,
    input  logic [SEL_W-1:0]        conf_pe_sel,
    output logic [PE_NUM-1:0]       pbuf_rd_en,
    output logic [ADDR_W-1:0]       pbuf_rd_addr,
    input  logic [PE_NUM*DDR_W-1:0] pbuf_rd_data,
    output logic [DDR_W-1:0]        ddr_data,
    output logic                    ddr_valid,
    input  logic                    ddr_ready
`ifdef PBUF2DDR_CHECKSUM_EN
    ,
    output logic [DDR_W-1:0]        chk_sum
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       trans_num_q, trans_num_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [7:0]       rd_cnt_q, rd_cnt_d;
    logic [7:0]       sent_cnt_q, sent_cnt_d;
    logic [RD_LAT-1:0] pipe_q, pipe_d;

    logic [DDR_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

    logic             issue;
    logic             push;
    logic             pop;
    logic             credit_ok;
    int               inflight;
    logic [DDR_W-1:0] push_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    // Every issued read holds a FIFO slot from issue until pop, so a push can never hit a full FIFO.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < RD_LAT; i++) inflight += int'(pipe_q[i]);
    end
    assign credit_ok = (int'(fifo_cnt_q) + inflight) < FIFO_DEPTH;

    assign push      = pipe_q[RD_LAT-1];
    assign push_data = pbuf_rd_data[int'(sel_q)*DDR_W +: DDR_W];
    assign ddr_valid = (fifo_cnt_q != '0);
    assign ddr_data  = fifo_mem[rd_ptr_q];
    assign pop       = ddr_valid && ddr_ready;
    assign done      = (state_q == S_IDLE);
    assign pbuf_rd_addr = ADDR_W'(rd_cnt_q);

    always_comb begin
        state_d     = state_q;
        trans_num_d = trans_num_q;
        sel_d       = sel_q;
        rd_cnt_d    = rd_cnt_q;
        sent_cnt_d  = sent_cnt_q;
        issue       = 1'b0;
        if (pop) sent_cnt_d = sent_cnt_q + 8'd1;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_READ;
                    trans_num_d = conf_trans_num;
                    sel_d       = conf_pe_sel;
                    rd_cnt_d    = '0;
                    sent_cnt_d  = '0;
                end
            end
            S_READ: begin
                if (credit_ok) begin
                    issue    = 1'b1;
                    rd_cnt_d = rd_cnt_q + 8'd1;
                    if (rd_cnt_q == trans_num_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && sent_cnt_q == trans_num_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pbuf_rd_en = '0;
        if (issue) pbuf_rd_en[sel_q] = 1'b1;
    end

    always_comb begin
        pipe_d     = RD_LAT'({pipe_q, issue});
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            trans_num_q <= '0;
            sel_q       <= '0;
            rd_cnt_q    <= '0;
            sent_cnt_q  <= '0;
            pipe_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            trans_num_q <= trans_num_d;
            sel_q       <= sel_d;
            rd_cnt_q    <= rd_cnt_d;
            sent_cnt_q  <= sent_cnt_d;
            pipe_q      <= pipe_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    // Storage needs no reset: the count gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= push_data;
    end

`ifdef PBUF2DDR_CHECKSUM_EN
    logic [DDR_W-1:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (state_q == S_IDLE && start) chk_d = '0;
        else if (pop)                   chk_d = chk_q ^ ddr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) chk_q <= '0;
        else     chk_q <= chk_d;
    end

    assign chk_sum = chk_q;
`endif

endmodule

// File: tb/tb_pbuf2ddr.sv
// Self-checking bench for pbuf2ddr: random buffer contents and DDR backpressure against a queue-based model.
module tb_pbuf2ddr;
    localparam int BUF_DEPTH = 256;
    localparam int ADDR_W    = 8;
    localparam int PE_NUM    = 32;
    localparam int SEL_W     = 5;
    localparam int RD_LAT    = 2;
    localparam int DDR_W     = 64;
    localparam int LANES_W   = PE_NUM * DDR_W;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               done;
    logic [7:0]         conf_trans_num = '0;
    logic [SEL_W-1:0]   conf_pe_sel = '0;
    logic [PE_NUM-1:0]  pbuf_rd_en;
    logic [ADDR_W-1:0]  pbuf_rd_addr;
    logic [LANES_W-1:0] pbuf_rd_data;
    logic [DDR_W-1:0]   ddr_data;
    logic               ddr_valid;
    logic               ddr_ready = 1'b0;
`ifdef PBUF2DDR_CHECKSUM_EN
    logic [DDR_W-1:0]   chk_sum;
`endif

    pbuf2ddr dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .done           (done),
        .conf_trans_num (conf_trans_num),
        .conf_pe_sel    (conf_pe_sel),
        .pbuf_rd_en     (pbuf_rd_en),
        .pbuf_rd_addr   (pbuf_rd_addr),
        .pbuf_rd_data   (pbuf_rd_data),
        .ddr_data       (ddr_data),
        .ddr_valid      (ddr_valid),
        .ddr_ready      (ddr_ready)
`ifdef PBUF2DDR_CHECKSUM_EN
        ,
        .chk_sum        (chk_sum)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DDR_W-1:0] bufmem [PE_NUM][BUF_DEPTH];
    logic [DDR_W-1:0] exp_q[$];
    logic [DDR_W-1:0] rcv_q[$];
    logic [LANES_W-1:0] dpipe [RD_LAT];
    int cyc = 0;
    int t0 = 0;
    int n_words = 0;
    int issue_cnt = 0;
    int done_rel = 0;
    int ready_mode = 0;
    int cur_sel = 0;
    bit timing_chk = 0;
    bit checking = 0;
    logic [DDR_W-1:0] exp_xor;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    // Buffer model: every lane reads back RD_LAT cycles after an issue; junk otherwise so mistimed pushes show up.
    function automatic logic [LANES_W-1:0] gen_lanes(input logic en, input logic [ADDR_W-1:0] a);
        logic [LANES_W-1:0] r;
        for (int p = 0; p < PE_NUM; p++)
            r[p*DDR_W +: DDR_W] = en ? bufmem[p][a] : {$urandom, $urandom};
        return r;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        dpipe[0] <= gen_lanes(|pbuf_rd_en, pbuf_rd_addr);
        for (int k = 1; k < RD_LAT; k++) dpipe[k] <= dpipe[k-1];
    end
    assign pbuf_rd_data = dpipe[RD_LAT-1];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ddr_ready = 1'b1;
                1:       ddr_ready = 1'($urandom_range(0, 1));
                default: ddr_ready = 1'b0;
            endcase
        end
    end

    initial begin
        logic             prev_valid = 1'b0;
        logic             prev_ready = 1'b0;
        logic             prev_done  = 1'b1;
        logic [DDR_W-1:0] prev_data  = '0;
        logic [PE_NUM-1:0] oh;
        logic [DDR_W-1:0] w;
        forever begin
            @(negedge clk);
            if (checking && !rst) begin
                if (pbuf_rd_en != '0) begin
                    oh = '0;
                    oh[cur_sel] = 1'b1;
                    check("rd_en_onehot", 64'(pbuf_rd_en), 64'(oh));
                    check("rd_addr", 64'(pbuf_rd_addr), 64'(issue_cnt % BUF_DEPTH));
                    if (issue_cnt >= n_words) fail("extra_read");
                    issue_cnt++;
                end
                if (prev_valid && !prev_ready) begin
                    check("stall_valid", 64'(ddr_valid), 64'd1);
                    check("stall_data", ddr_data, prev_data);
                end
                if (ddr_valid && ddr_ready) begin
                    if (exp_q.size() == 0) begin
                        fail("unexpected_word");
                    end else begin
                        w = exp_q.pop_front();
                        check("ddr_data", ddr_data, w);
                    end
                    rcv_q.push_back(ddr_data);
                end
                if (done && !prev_done) begin
                    done_rel = cyc - t0;
                    if (timing_chk) check("done_rise", 64'(done_rel), 64'(2 + RD_LAT + n_words));
                end
                prev_valid = ddr_valid;
                prev_ready = ddr_ready;
                prev_data  = ddr_data;
                prev_done  = done;
            end else begin
                prev_valid = 1'b0;
                prev_done  = 1'b1;
            end
        end
    end

    task automatic start_xfer(input int tn, input int sel, input int rmode);
        n_words    = tn + 1;
        cur_sel    = sel;
        issue_cnt  = 0;
        ready_mode = rmode;
        timing_chk = (rmode == 0);
        rcv_q.delete();
        exp_q.delete();
        exp_xor = '0;
        for (int a = 0; a < n_words; a++) begin
            exp_q.push_back(bufmem[sel][a]);
            exp_xor ^= bufmem[sel][a];
        end
        @(posedge clk);
        #1;
        start          = 1'b1;
        conf_trans_num = 8'(tn);
        conf_pe_sel    = SEL_W'(sel);
        t0             = cyc;
        checking       = 1'b1;
        @(posedge clk);
        #1;
        start          = 1'b0;
        conf_trans_num = 8'($urandom);
        conf_pe_sel    = SEL_W'($urandom);
        check("done_low", 64'(done), 64'd0);
`ifdef PBUF2DDR_CHECKSUM_EN
        check("chk_clear", chk_sum, 64'd0);
`endif
    endtask

    task automatic finish_xfer();
        for (int i = 0; i < n_words * 8 + 50; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done_reached", 64'(done), 64'd1);
        check("words_left", 64'(exp_q.size()), 64'd0);
        check("issue_count", 64'(issue_cnt), 64'(n_words));
`ifdef PBUF2DDR_CHECKSUM_EN
        check("chk_sum", chk_sum, exp_xor);
`endif
    endtask

    initial begin
        for (int p = 0; p < PE_NUM; p++)
            for (int a = 0; a < BUF_DEPTH; a++)
                bufmem[p][a] = {$urandom, $urandom};
        for (int k = 0; k < RD_LAT; k++) dpipe[k] = '0;

        #12;
        check("rst_done", 64'(done), 64'd1);
        check("rst_valid", 64'(ddr_valid), 64'd0);
        check("rst_rd_en", 64'(pbuf_rd_en), 64'd0);
        check("rst_addr", 64'(pbuf_rd_addr), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int a = 0; a < BUF_DEPTH; a++) bufmem[5][a] = {4{16'(a + 'h100)}};
        start_xfer(7, 5, 0);
        finish_xfer();
        check("t1_first_word", rcv_q.size() > 0 ? rcv_q[0] : '1, 64'h0100_0100_0100_0100);
        check("t1_last_word", rcv_q.size() > 7 ? rcv_q[7] : '1, 64'h0107_0107_0107_0107);
        check("t1_done_cycle", 64'(done_rel), 64'd12);

        start_xfer(15, int'($urandom_range(0, PE_NUM-1)), 1);
        finish_xfer();

        start_xfer(0, 9, 0);
        finish_xfer();
        check("t3_done_cycle", 64'(done_rel), 64'd5);

        start_xfer(255, int'($urandom_range(0, PE_NUM-1)), 0);
        finish_xfer();
        check("t4_done_cycle", 64'(done_rel), 64'd260);

        start_xfer(15, 17, 0);
        for (int i = 0; i < 100 && rcv_q.size() < 3; i++) @(negedge clk);
        ready_mode = 2;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2;
        checking = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_valid", 64'(ddr_valid), 64'd0);
        check("abort_done", 64'(done), 64'd1);
        check("abort_rd_en", 64'(pbuf_rd_en), 64'd0);
        check("abort_addr", 64'(pbuf_rd_addr), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        start_xfer(3, 17, 0);
        finish_xfer();

`ifdef PBUF2DDR_CHECKSUM_EN
        bufmem[3][0] = 64'h1;
        bufmem[3][1] = 64'h2;
        bufmem[3][2] = 64'h4;
        start_xfer(2, 3, 0);
        finish_xfer();
        check("chk_literal", chk_sum, 64'h7);
`endif

        for (int r = 0; r < 4; r++) begin
            start_xfer(int'($urandom_range(0, 40)), int'($urandom_range(0, PE_NUM-1)),
                       int'($urandom_range(0, 1)));
            finish_xfer();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
